// File: rtl/axis_adc_acq_ctrl.sv
// rtl/axis_adc_acq_ctrl.sv - triggered two-channel ADC acquisition controller with AXI-Stream output
module axis_adc_acq_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        arm,
    input  logic                        trigger,
    input  logic                        abort,
    input  logic [CNTR_WIDTH-1:0]       cfg_delay,
    input  logic [CNTR_WIDTH-1:0]       cfg_count,
    input  logic [1:0]                  cfg_mode,
    input  logic                        s0_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                        s1_axis_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [1:0]                  sts_state,
    output logic                        sts_overrun,
    output logic [CNTR_WIDTH-1:0]       sts_count
);

    localparam int HALF = AXIS_TDATA_WIDTH / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_ACQ,
        S_DONE
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic                          trigger_q;
    logic [CNTR_WIDTH-1:0]         delay_cnt;
    logic [CNTR_WIDTH-1:0]         lat_delay;
    logic [CNTR_WIDTH-1:0]         lat_count;
    logic [1:0]                    lat_mode;
    logic [AXIS_TDATA_WIDTH-1:0]   sample_word;

    logic                          trig_edge;
    logic                          arm_accept;
    logic                          strobe;
    logic                          out_free;
    logic                          load;
    logic                          drop;
    logic [CNTR_WIDTH-1:0]         eff_count;
    logic [CNTR_WIDTH-1:0]         count_inc;
    logic                          load_last;
    logic                          handshake_last;

    assign trig_edge      = trigger & ~trigger_q;
    assign arm_accept     = (state == S_IDLE) & arm & ~abort;
    assign strobe         = (state == S_ACQ) & s0_axis_tvalid & s1_axis_tvalid;
    // A new word may enter the output register when it is empty or being drained this cycle.
    assign out_free       = ~m_axis_tvalid | m_axis_tready;
    assign load           = strobe & out_free & ~abort;
    assign drop           = strobe & ~out_free & ~abort;
    assign eff_count      = (lat_count == '0) ? CNTR_WIDTH'(1) : lat_count;
    assign count_inc      = (&sts_count) ? sts_count : sts_count + CNTR_WIDTH'(1);
    assign load_last      = (count_inc == eff_count);
    assign handshake_last = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Select the output word from the channels according to the latched mode.
    always_comb begin
        sample_word = s0_axis_tdata;
        case (lat_mode)
            2'b01:   sample_word = s1_axis_tdata;
            2'b10:   sample_word = {s1_axis_tdata[HALF-1:0], s0_axis_tdata[HALF-1:0]};
            default: sample_word = s0_axis_tdata;
        endcase
    end

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other request.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (arm) state_next = S_ARMED;
                S_ARMED: if (trig_edge) state_next = (lat_delay == '0) ? S_ACQ : S_DELAY;
                S_DELAY: if (delay_cnt <= CNTR_WIDTH'(1)) state_next = S_ACQ;
                S_ACQ:   if (load && load_last) state_next = S_DONE;
                S_DONE:  if (handshake_last) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Status encoding folds ACQ and DONE into one code.
    always_comb begin
        sts_state = 2'd3;
        case (state)
            S_IDLE:  sts_state = 2'd0;
            S_ARMED: sts_state = 2'd1;
            S_DELAY: sts_state = 2'd2;
            default: sts_state = 2'd3;
        endcase
    end

    // Trigger edge history, configuration capture on arm, and post-trigger delay countdown.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            trigger_q <= 1'b0;
            delay_cnt <= '0;
            lat_delay <= '0;
            lat_count <= '0;
            lat_mode  <= 2'b00;
        end else begin
            trigger_q <= trigger;
            if (arm_accept) begin
                lat_delay <= cfg_delay;
                lat_count <= cfg_count;
                lat_mode  <= cfg_mode;
            end
            if (abort) begin
                delay_cnt <= '0;
            end else if (state == S_ARMED && trig_edge) begin
                delay_cnt <= lat_delay;
            end else if (state == S_DELAY && delay_cnt != '0) begin
                delay_cnt <= delay_cnt - CNTR_WIDTH'(1);
            end
        end
    end

    // Output register, sample counter and sticky overrun flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            sts_overrun   <= 1'b0;
            sts_count     <= '0;
        end else if (abort) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (load) begin
                m_axis_tdata  <= sample_word;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= load_last;
                sts_count     <= count_inc;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            if (drop) begin
                sts_overrun <= 1'b1;
            end
            if (arm_accept) begin
                sts_count   <= '0;
                sts_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_adc_acq_ctrl.sv
// tb/tb_axis_adc_acq_ctrl.sv - directed self-checking bench for axis_adc_acq_ctrl
module tb_axis_adc_acq_ctrl;

    logic        aclk;
    logic        areset;
    logic        arm;
    logic        trigger;
    logic        abort;
    logic [31:0] cfg_delay;
    logic [31:0] cfg_count;
    logic [1:0]  cfg_mode;
    logic        s0_axis_tvalid;
    logic [31:0] s0_axis_tdata;
    logic        s1_axis_tvalid;
    logic [31:0] s1_axis_tdata;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [1:0]  sts_state;
    logic        sts_overrun;
    logic [31:0] sts_count;

    int total = 0;
    int bad   = 0;

    axis_adc_acq_ctrl #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .arm            (arm),
        .trigger        (trigger),
        .abort          (abort),
        .cfg_delay      (cfg_delay),
        .cfg_count      (cfg_count),
        .cfg_mode       (cfg_mode),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tdata  (s0_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tdata  (s1_axis_tdata),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .sts_state      (sts_state),
        .sts_overrun    (sts_overrun),
        .sts_count      (sts_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [31:0] d, input logic [31:0] c, input logic [1:0] m);
        cfg_delay = d;
        cfg_count = c;
        cfg_mode  = m;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_state", {30'd0, sts_state}, 32'd1);
    endtask

    initial begin
        areset = 1'b1;
        arm = 1'b0;
        trigger = 1'b0;
        abort = 1'b0;
        cfg_delay = '0;
        cfg_count = '0;
        cfg_mode = 2'b00;
        s0_axis_tvalid = 1'b1;
        s1_axis_tvalid = 1'b1;
        s0_axis_tdata = 32'h0;
        s1_axis_tdata = 32'h0;
        m_axis_tready = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();

        chk("rst_state", {30'd0, sts_state}, 32'd0);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_count", sts_count, 32'd0);
        chk("rst_overrun", {31'd0, sts_overrun}, 32'd0);

        // delay 3, count 4, channel 0, continuous ready
        do_arm(32'd3, 32'd4, 2'b00);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t1_delay1", {30'd0, sts_state}, 32'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t1_delay2", {30'd0, sts_state}, 32'd2);
        tick();
        chk("t1_delay3", {30'd0, sts_state}, 32'd2);
        tick();
        chk("t1_acq_state", {30'd0, sts_state}, 32'd3);
        chk("t1_acq_novalid", {31'd0, m_axis_tvalid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            s0_axis_tdata = 32'h0000_00A0 + k;
            tick();
            chk("t1_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("t1_tdata", m_axis_tdata, 32'h0000_00A0 + k);
            chk("t1_tlast", {31'd0, m_axis_tlast}, (k == 3) ? 32'd1 : 32'd0);
            chk("t1_count", sts_count, 32'd1 + k);
        end
        chk("t1_done_state", {30'd0, sts_state}, 32'd3);
        tick();
        chk("t1_idle", {30'd0, sts_state}, 32'd0);
        chk("t1_idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t1_final_count", sts_count, 32'd4);

        // packed mode, count 0 and delay 0
        s0_axis_tdata = 32'hFFFF_1234;
        s1_axis_tdata = 32'h5555_ABCD;
        do_arm(32'd0, 32'd0, 2'b10);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t2_acq_now", {30'd0, sts_state}, 32'd3);
        tick();
        chk("t2_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("t2_packed", m_axis_tdata, 32'hABCD_1234);
        chk("t2_tlast", {31'd0, m_axis_tlast}, 32'd1);
        chk("t2_count", sts_count, 32'd1);
        tick();
        chk("t2_idle", {30'd0, sts_state}, 32'd0);

        // count 8, channel 1, three stalled cycles
        do_arm(32'd1, 32'd8, 2'b01);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t3_delay", {30'd0, sts_state}, 32'd2);
        tick();
        chk("t3_acq", {30'd0, sts_state}, 32'd3);
        for (int k = 0; k < 2; k++) begin
            s1_axis_tdata = 32'h0000_00B0 + k;
            tick();
            chk("t3_pre_tdata", m_axis_tdata, 32'h0000_00B0 + k);
            chk("t3_pre_count", sts_count, 32'd1 + k);
        end
        m_axis_tready = 1'b0;
        for (int k = 2; k < 5; k++) begin
            s1_axis_tdata = 32'h0000_00B0 + k;
            tick();
            chk("t3_hold_tdata", m_axis_tdata, 32'h0000_00B1);
            chk("t3_hold_count", sts_count, 32'd2);
            chk("t3_overrun", {31'd0, sts_overrun}, 32'd1);
            chk("t3_hold_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        end
        m_axis_tready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            s1_axis_tdata = 32'h0000_00C0 + j;
            tick();
            chk("t3_tdata", m_axis_tdata, 32'h0000_00C0 + j);
            chk("t3_count", sts_count, 32'd3 + j);
            chk("t3_tlast", {31'd0, m_axis_tlast}, (j == 5) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t3_idle", {30'd0, sts_state}, 32'd0);
        chk("t3_overrun_sticky", {31'd0, sts_overrun}, 32'd1);
        chk("t3_final_count", sts_count, 32'd8);

        // abort with a pending word
        do_arm(32'd0, 32'd8, 2'b00);
        chk("t4_overrun_cleared", {31'd0, sts_overrun}, 32'd0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        chk("t4_pending", {31'd0, m_axis_tvalid}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_idle", {30'd0, sts_state}, 32'd0);
        chk("t4_abort_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t4_abort_tlast", {31'd0, m_axis_tlast}, 32'd0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t4_trig_ignored", {30'd0, sts_state}, 32'd0);
        tick();
        chk("t4_still_idle", {30'd0, sts_state}, 32'd0);

        // asynchronous reset in DELAY
        m_axis_tready = 1'b1;
        do_arm(32'd5, 32'd2, 2'b00);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t5_delay", {30'd0, sts_state}, 32'd2);
        #2;
        areset = 1'b1;
        #1;
        chk("t5_async_state", {30'd0, sts_state}, 32'd0);
        chk("t5_async_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("t5_async_tdata", m_axis_tdata, 32'd0);
        chk("t5_async_count", sts_count, 32'd0);
        tick();
        areset = 1'b0;
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t5_need_arm", {30'd0, sts_state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_adc_acq_ctrl.md
AXIS_ADC_ACQ_CTRL -- requirements
Module: axis_adc_acq_ctrl

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, sets the data width of the input and output streams (even; halves = AXIS_TDATA_WIDTH/2).
REQ-002 Parameter CNTR_WIDTH, default 32, sets the width of the delay counter, the sample counter and the status counter.
REQ-003 aclk  in  1  single clock; all logic on rising edge.
REQ-004 areset  in  1  reset, asynchronous, active-high.
REQ-005 arm  in  1  level; IDLE->ARMED request; cfg_* latched when accepted.
REQ-006 trigger  in  1  external trigger, rising edge detected.
REQ-007 abort  in  1  level; forces IDLE.
REQ-008 cfg_delay  in  CNTR_WIDTH  post-trigger delay in aclk cycles.
REQ-009 cfg_count  in  CNTR_WIDTH  samples per acquisition (0 treated as 1).
REQ-010 cfg_mode  in  2  00 channel 0, 01 channel 1, 10 packed {s1 low half, s0 low half}, 11 same as 00.
REQ-011 s0_axis_tvalid / s0_axis_tdata  in  1 / AXIS_TDATA_WIDTH  ADC channel 0 stream, no backpressure.
REQ-012 s1_axis_tvalid / s1_axis_tdata  in  1 / AXIS_TDATA_WIDTH  ADC channel 1 stream, no backpressure.
REQ-013 m_axis_tready  in  1; m_axis_tvalid  out  1; m_axis_tdata  out  AXIS_TDATA_WIDTH; m_axis_tlast  out  1  acquisition output stream.
REQ-014 sts_state  out  2  IDLE=0, ARMED=1, DELAY=2, ACQ/DONE=3.
REQ-015 sts_overrun  out  1  sticky dropped-sample flag.
REQ-016 sts_count  out  CNTR_WIDTH  samples loaded in current/last acquisition.

Function
REQ-017 States: IDLE, ARMED, DELAY, ACQ, DONE; one state transition per cycle maximum.
REQ-018 IDLE: arm=1 -> ARMED next cycle; cfg_delay, cfg_count, cfg_mode latched; sts_count and sts_overrun cleared same edge.
REQ-019 Trigger edge = trigger & ~trigger_q (trigger_q one register); edges outside ARMED ignored.
REQ-020 ARMED: edge in cycle t -> DELAY at t+1 with delay counter loaded to latched cfg_delay; if cfg_delay=0 -> ACQ at t+1 instead.
REQ-021 DELAY: counter decrements each cycle; value 1 -> ACQ next cycle (exactly cfg_delay cycles in DELAY).
REQ-022 Sample strobe in ACQ = s0_axis_tvalid & s1_axis_tvalid; no strobe in any other state.
REQ-023 Strobe with output register empty or draining (m_axis_tvalid=0 or m_axis_tready=1): word loaded, m_axis_tvalid=1 next cycle (latency 1), sts_count +1.
REQ-024 Strobe with m_axis_tvalid=1 and m_axis_tready=0: sample dropped, sts_overrun=1, sts_count unchanged; held word unchanged.
REQ-025 Word loaded when sts_count reaches effective count carries m_axis_tlast=1; same edge ACQ -> DONE.
REQ-026 DONE: no strobes; stays until tlast word handshaken (tvalid & tready & tlast) -> IDLE next cycle.
REQ-027 m_axis_tvalid deasserts only on handshake; tdata/tlast stable while tvalid=1 and tready=0.
REQ-028 abort=1 in any state -> IDLE next cycle, m_axis_tvalid and m_axis_tlast cleared (pending word discarded); abort dominates arm and trigger in same cycle.
REQ-029 arm while not IDLE ignored; cfg_* changes after latching have no effect until next arm.
REQ-030 sts_count saturates at all-ones; counters use CNTR_WIDTH unsigned arithmetic, no wrap.

Reset
REQ-031 areset=1 asynchronously: state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, sts_overrun=0, sts_count=0, trigger_q=0, delay counter 0.
REQ-032 Reset mid-acquisition discards any pending word; first action after release requires a new arm.

Verification
REQ-033 cfg_delay=3, cfg_count=4, mode 00, tready=1, inputs valid every cycle: trigger edge at t -> DELAY t+1..t+3, ACQ t+4, four words t+5..t+8, tlast only at t+8, IDLE at t+9, sts_count=4.
REQ-034 Mode 10, s0 low half 0x1234, s1 low half 0xABCD -> m_axis_tdata=0xABCD1234.
REQ-035 cfg_count=8, tready=0 for 3 cycles mid-run: 3 samples dropped, sts_overrun=1, still exactly 8 words output, last with tlast.
REQ-036 cfg_count=0, cfg_delay=0: one word with tlast, ACQ entered cycle after trigger edge.
REQ-037 abort asserted in ACQ with tready=0 and word pending: next cycle IDLE, m_axis_tvalid=0; following trigger ignored until arm.
REQ-038 areset pulsed during DELAY: outputs at REQ-031 values immediately, no clock needed.
